mux_nx1_pipe: RTL and testbench

//  Parametrised N-input, W-bit multiplexer for the datapath (ALU-source, writeback, PC-source selection).

---
 rtl/mux_nx1_pipe.sv | 162 ++++++++++++++++
 tb/tb_mux_nx1_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_nx1_pipe.sv
// N-input, W-bit select mux with a registered output and a 2-entry skid buffer (valid/ready on both sides).
// Optional macro MUX_SEL_ERR_EN adds out_err (per item) and err_seen (sticky) for selects >= N.
module mux_nx1_pipe #(
  parameter  int W  = 32,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_sel
`ifdef MUX_SEL_ERR_EN
  ,
  output logic            out_err,
  output logic            err_seen
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    main_data_q, main_data_d;
  logic [SW-1:0]   main_sel_q, main_sel_d;
  logic [W-1:0]    skid_data_q, skid_data_d;
  logic [SW-1:0]   skid_sel_q, skid_sel_d;
  logic            accept, pop;
  logic            ld_main_in, ld_main_skid, ld_skid;
  logic [W-1:0]    mux_data;

  // Selects with no matching input fall through to zero, never X.
  function automatic logic [W-1:0] mux_sel(input logic [N*W-1:0] d, input logic [SW-1:0] s);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++)
      if (s == SW'(k)) r = d[k*W +: W];
    return r;
  endfunction

  assign in_ready  = (state_q != TWO) & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign mux_data  = mux_sel(in_data, sel);

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          ld_main_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          ld_main_in = 1'b1;
        end else if (accept) begin
          ld_skid = 1'b1;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          ld_main_skid = 1'b1;
          state_d      = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    if (ld_main_in) begin
      main_data_d = mux_data;
      main_sel_d  = sel;
    end else if (ld_main_skid) begin
      main_data_d = skid_data_q;
      main_sel_d  = skid_sel_q;
    end
    if (ld_skid) begin
      skid_data_d = mux_data;
      skid_sel_d  = sel;
    end
  end

  // Output stage: cleared on reset so a discarded item never shows up on out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_sel_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
    end
  end

  // Skid contents are only meaningful in TWO, so they need no reset.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
    skid_sel_q  <= skid_sel_d;
  end

`ifdef MUX_SEL_ERR_EN
  logic mux_oob;
  logic main_err_q, main_err_d;
  logic skid_err_q, skid_err_d;
  logic err_seen_q, err_seen_d;

  function automatic logic sel_oob(input logic [SW-1:0] s);
    logic r;
    r = 1'b1;
    for (int k = 0; k < N; k++)
      if (s == SW'(k)) r = 1'b0;
    return r;
  endfunction

  assign mux_oob  = sel_oob(sel);
  assign out_err  = main_err_q;
  assign err_seen = err_seen_q;

  always_comb begin
    main_err_d = main_err_q;
    skid_err_d = skid_err_q;
    err_seen_d = err_seen_q | (accept & mux_oob);
    if (ld_main_in)        main_err_d = mux_oob;
    else if (ld_main_skid) main_err_d = skid_err_q;
    if (ld_skid)           skid_err_d = mux_oob;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_err_q <= 1'b0;
      skid_err_q <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      main_err_q <= main_err_d;
      skid_err_q <= skid_err_d;
      err_seen_q <= err_seen_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed and random checks of mux_nx1_pipe: a W=32/N=4 instance and a W=8/N=3 instance for out-of-range selects.
module tb_mux_nx1_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  sel, out_sel;
  logic [127:0] in_data;
  logic [31:0] out_data;

  logic        v3, rdy3_in, ov3, rdy3;
  logic [1:0]  sel3, osel3;
  logic [23:0] d3;
  logic [7:0]  od3;
`ifdef MUX_SEL_ERR_EN
  logic        oerr, eseen, oerr3, eseen3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_nx1_pipe #(.W(32), .N(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel)
`ifdef MUX_SEL_ERR_EN
    , .out_err(oerr), .err_seen(eseen)
`endif
  );

  mux_nx1_pipe #(.W(8), .N(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(v3), .in_ready(rdy3_in), .sel(sel3),
    .in_data(d3), .out_valid(ov3), .out_ready(rdy3), .out_data(od3),
    .out_sel(osel3)
`ifdef MUX_SEL_ERR_EN
    , .out_err(oerr3), .err_seen(eseen3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_q[$];
  logic [1:0]  exps_q[$];
  logic [31:0] w;
  logic [31:0] hold_data;
  logic [1:0]  hold_sel;
  logic        stalled;

  initial begin
    reset = 1'b1; in_valid = 0; sel = 0; in_data = '0; out_ready = 0;
    v3 = 0; sel3 = 0; d3 = '0; rdy3 = 0;

    // reset behaviour
    step(); step(); step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // streaming at full rate
    in_data = {32'hD, 32'hC, 32'hB, 32'hA};
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; sel = 2'(i);
      step();
      chk("str_valid", 64'(out_valid), 64'd1);
      chk("str_data", 64'(out_data), 64'hA + 64'(i));
      chk("str_sel", 64'(out_sel), 64'(i));
    end
    in_valid = 0;
    step();
    chk("str_drain", 64'(out_valid), 64'd0);

    // back-pressure into the skid buffer
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    out_ready = 0;
    in_valid = 1; sel = 0;
    step();
    chk("bp_ready1", 64'(in_ready), 64'd1);
    sel = 1;
    step();
    chk("bp_ready2", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(out_data), 64'h11);
    sel = 2;
    step();
    chk("bp_stall_data", 64'(out_data), 64'h11);
    chk("bp_stall_sel", 64'(out_sel), 64'd0);
    in_valid = 0; out_ready = 1;
    step();
    chk("bp_second", 64'(out_data), 64'h22);
    chk("bp_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // out-of-range select on the N=3 instance
    d3 = {8'h33, 8'h22, 8'h11};
    v3 = 1; sel3 = 3; rdy3 = 0;
    step();
    chk("oob_valid", 64'(ov3), 64'd1);
    chk("oob_data", 64'(od3), 64'd0);
    chk("oob_sel", 64'(osel3), 64'd3);
`ifdef MUX_SEL_ERR_EN
    chk("oob_err", 64'(oerr3), 64'd1);
    chk("oob_seen", 64'(eseen3), 64'd1);
`endif
    v3 = 0; rdy3 = 1;
    step();
    v3 = 1; sel3 = 2;
    step();
    v3 = 0;
    chk("n3_data", 64'(od3), 64'h33);
`ifdef MUX_SEL_ERR_EN
    chk("n3_err", 64'(oerr3), 64'd0);
    chk("n3_seen_sticky", 64'(eseen3), 64'd1);
`endif

    // reset while full
    out_ready = 0; in_valid = 1; sel = 2;
    step();
    sel = 3;
    step();
    in_valid = 0;
    chk("full_ready", 64'(in_ready), 64'd0);
    reset = 1;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
`ifdef MUX_SEL_ERR_EN
    chk("mid_rst_seen", 64'(eseen3), 64'd0);
`endif
    reset = 0;
    #1;
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    in_valid = 1; sel = 3; out_ready = 1;
    step();
    in_valid = 0;
    chk("after_rst_data", 64'(out_data), 64'h44);
    step();
    chk("after_rst_empty", 64'(out_valid), 64'd0);

    // random traffic against a queue scoreboard
    stalled = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sel       = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
      #1;
      if (stalled) begin
        chk("rnd_stable_data", 64'(out_data), 64'(hold_data));
        chk("rnd_stable_sel", 64'(out_sel), 64'(hold_sel));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd_spurious", 64'(out_valid), 64'd0);
        else begin
          chk("rnd_data", 64'(out_data), 64'(exp_q.pop_front()));
          chk("rnd_sel", 64'(out_sel), 64'(exps_q.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        w = in_data[sel*32 +: 32];
        exp_q.push_back(w);
        exps_q.push_back(sel);
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_sel  = out_sel;
      step();
    end
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid && exp_q.size() != 0) begin
        chk("drain_data", 64'(out_data), 64'(exp_q.pop_front()));
        chk("drain_sel", 64'(out_sel), 64'(exps_q.pop_front()));
      end
      step();
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
